// File: rtl/cache_pkg.sv
// Shared definitions for the instruction cache: controller states and
// address-field width helpers derived from the cache geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  function automatic int offset_bits(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int num_sets, input int words_per_line);
    return 32 - offset_bits(words_per_line) - index_bits(num_sets);
  endfunction

  // A direct-mapped cache still needs a 1-bit pointer to keep port widths legal.
  function automatic int way_bits(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: per-set valid bit, tag and line storage.
// Only the valid bits are reset; tag and line contents are don't-care until written.
module icache_way_array
  import cache_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 22,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i,
  input  logic              inv_all_i
);

  localparam int NUM_SETS = 1 << IDX_W;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   line_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/set_assoc_instruction_cache.sv
// Set-associative instruction cache with zero-latency hits, blocking line refill
// through a word-serial memory port, fence.i flush and a saturating miss counter.
module set_assoc_instruction_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS       = 64,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] program_counter_address,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        stall_cpu,
  output logic [31:0] instruction_memory_address,
  output logic        instruction_memory_request,
  input  logic [31:0] instruction_memory_read_data,
  input  logic        instruction_memory_ready,
  output logic [31:0] miss_count
);

  localparam int OFF_W   = offset_bits(WORDS_PER_LINE);
  localparam int IDX_W   = index_bits(NUM_SETS);
  localparam int TAG_W   = tag_bits(NUM_SETS, WORDS_PER_LINE);
  localparam int WORD_W  = OFF_W - 2;
  localparam int WAY_W   = way_bits(NUM_WAYS);
  localparam int LINE_W  = 32 * WORDS_PER_LINE;
  localparam int MADDR_W = TAG_W + IDX_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  state_e state_q, state_d;
  logic [MADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [WORD_W-1:0]  word_ctr_q, word_ctr_d;
  logic               flush_pend_q, flush_pend_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
  logic [WAY_W-1:0]   rr_q [NUM_SETS];
  logic [WORDS_PER_LINE-1:0][31:0] refill_q;

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [WORD_W-1:0] pc_word;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              unused_pc_bits;

  assign pc_tag   = program_counter_address[31 -: TAG_W];
  assign pc_idx   = program_counter_address[OFF_W +: IDX_W];
  assign pc_word  = program_counter_address[2 +: WORD_W];
  assign miss_tag = miss_addr_q[MADDR_W-1 -: TAG_W];
  assign miss_idx = miss_addr_q[IDX_W-1:0];
  assign unused_pc_bits = ^program_counter_address[1:0];

  // Outside IDLE the arrays are looked up with the latched miss set, never the live PC.
  assign rd_idx = (state_q == ST_IDLE) ? pc_idx : miss_idx;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_wr;
  logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
  logic [LINE_W-1:0]   way_line [NUM_WAYS];
  logic                inv_all;
  logic                fill_en;
  logic                rr_adv;
  logic [WAY_W-1:0]    victim;
  logic                victim_free;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign way_wr[w] = fill_en && (victim == WAY_W'(w));

    icache_way_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .LINE_W(LINE_W)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx_i  (rd_idx),
      .rd_valid_o(way_valid[w]),
      .rd_tag_o  (way_tag[w]),
      .rd_line_o (way_line[w]),
      .wr_en_i   (way_wr[w]),
      .wr_idx_i  (miss_idx),
      .wr_tag_i  (miss_tag),
      .wr_line_i (refill_q),
      .inv_all_i (inv_all)
    );
  end

  logic                            hit;
  logic [WORDS_PER_LINE-1:0][31:0] hit_line;

  // At most one way can match, so OR-ing the matching lines is a clean mux.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == pc_tag)) begin
        hit      = 1'b1;
        hit_line = hit_line | way_line[w];
      end
    end
  end

  always_comb begin
    victim      = rr_q[miss_idx];
    victim_free = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim      = WAY_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    word_ctr_d   = word_ctr_q;
    flush_pend_d = flush_pend_q;
    miss_cnt_d   = miss_cnt_q;
    stall_cpu    = 1'b1;
    instruction  = '0;
    instruction_memory_request = 1'b0;
    instruction_memory_address = '0;
    inv_all = 1'b0;
    fill_en = 1'b0;
    rr_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          inv_all = 1'b1;
        end else if (hit) begin
          stall_cpu   = 1'b0;
          instruction = hit_line[pc_word];
        end else begin
          miss_addr_d = program_counter_address[31:OFF_W];
          miss_cnt_d  = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        instruction_memory_request = 1'b1;
        instruction_memory_address = {miss_addr_q, word_ctr_q, 2'b00};
        if (flush) flush_pend_d = 1'b1;
        if (instruction_memory_ready) begin
          word_ctr_d = word_ctr_q + 1'b1;
          if (word_ctr_q == LAST_WORD) state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // A flush seen during the burst discards the line instead of installing it.
        if (flush_pend_q || flush) begin
          inv_all = 1'b1;
        end else begin
          fill_en = 1'b1;
          rr_adv  = ~victim_free;
        end
        flush_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= '0;
      word_ctr_q   <= '0;
      flush_pend_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      word_ctr_q   <= word_ctr_d;
      flush_pend_q <= flush_pend_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (rr_adv) begin
      rr_q[miss_idx] <= (rr_q[miss_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[miss_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_FETCH) && instruction_memory_ready) begin
      refill_q[word_ctr_q] <= instruction_memory_read_data;
    end
  end

  assign miss_count = miss_cnt_q;

endmodule
